column_encoder: RTL and testbench
=================================

// Module: column_encoder
// PURPOSE
//  Avalon-MM master that streams one frame of raycaster column records into column_decoder.
//  Accepts 640 column records per frame over a valid/ready handshake.
//  Serialises each record into the decoder's 5-beat write sequence on address 1, preceded per frame by a column-reset write on address 0.
//  Optionally polls the decoder's vblank status (read, bit 0) before starting a frame.
// PARAMETERS
//  NCOLS        640  columns per frame; count wraps to 0 after NCOLS-1
//  WAIT_VBLANK  1    1: poll status until readdata[0]==1 before the frame reset write
//  ADDR_RESET   0    address of the column-counter reset write
//  ADDR_COL     1    address of the column data beats
//  ADDR_STATUS  0    address polled for vblank
// PORTS
//  clk              in   1   system clock (50 MHz)
//  reset            in   1   asynchronous, active-high
//  frame_start      in   1   one-cycle pulse: begin a frame
//  col_valid        in   1   column record valid
//  col_ready        out  1   block accepts record (valid&ready = transfer)
//  col_top          in   16  signed wall top row
//  col_height       in   16  wall height in rows
//  col_wall_dir     in   1   1 = full-brightness face
//  col_tex_type     in   3   texture select 0..7
//  col_tex_col      in   6   texture column 0..63
//  col_sf           in   32  texture row scale factor, fixed point
//  avm_address      out  4   Avalon address
//  avm_write        out  1   Avalon write
//  avm_writedata    out  16  Avalon write data
//  avm_read         out  1   Avalon read
//  avm_readdata     in   16  Avalon read data; bit 0 = vblank
//  avm_waitrequest  in   1   Avalon stall
//  busy             out  1   high in every state except IDLE
//  frame_done       out  1   one-cycle pulse after the last beat of column NCOLS-1
//  col_count        out  10  index of the next column to send
//  err_overrun      out  1   sticky: frame_start seen while busy
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE.
//  Reset is asynchronous and may hit mid-beat. The write drops immediately; this is allowed only under system reset.
//  Bus rule: address, write, read and writedata are registered and held stable while waitrequest=1. A beat completes on (write|read)&!waitrequest.
//  States:
//   IDLE:  frame_start -> VSYNC if WAIT_VBLANK, else RSTW. err_overrun clears on an accepted frame_start.
//   VSYNC: read=1, address=ADDR_STATUS. On completion with readdata[0]=1 -> RSTW. Otherwise re-issue the read next cycle.
//   RSTW:  write=1, address=ADDR_RESET, data 0. On completion: col_count<=0, -> WAITC.
//   WAITC: col_ready=1. On valid&ready, capture the record and go to SEND with beat=0. First write is asserted the next cycle.
//   SEND:  write=1, address=ADDR_COL. Beats 0..4 carry, in order:
//          {6'b0,wall_dir,tex_type,tex_col}, height, top, sf[31:16], sf[15:0].
//          On completion of beat 4:
//          - col_count==NCOLS-1: col_count<=0, pulse frame_done, -> IDLE.
//          - otherwise: col_count+1, -> WAITC.
//  col_ready is 0 in all other states. Records offered outside WAITC stall and are never dropped.
//  frame_start while busy is ignored, sets err_overrun and does not disturb the frame.
//  Throughput: no waitrequest -> 6 cycles/column (accept + 5 beats). Frame = 1 + 6*NCOLS cycles, plus vblank wait if enabled.
//  read and write are never asserted together.
// TESTING
//  T1 WAIT_VBLANK=0, no stall. Send NCOLS records with top=i, height=2i, tex=i%8, sf=0x01000000+i:
//     one addr-0 write, then 5*NCOLS addr-1 beats with exact data order.
//     frame_done pulses once, 3841 cycles after frame_start; col_count=0 afterwards.
//  T2 Random waitrequest 0-3 cycles per beat: address/writedata stay stable while stalled; beat sequence identical to T1.
//  T3 WAIT_VBLANK=1, readdata[0]=0 for 5 polls then 1: six reads at address 0, then the reset write; no writes before that.
//  T4 frame_start pulse at column 100: err_overrun=1, frame unaffected. Next idle frame_start clears it.
//  T5 col_valid held continuously: col_ready high only 1 cycle in 6; no record lost or duplicated.
//  T6 Async reset asserted during beat 2 of column 7: all outputs 0 at once. New frame_start then restarts from the reset write with col_count=0.

Source files
------------

// File: rtl/column_encoder.sv
// Avalon-MM master that serialises one frame of raycaster column records into
// column_decoder: optional vblank poll, a column-reset write, then 5 beats per column.
module column_encoder #(
  parameter int          NCOLS       = 640,
  parameter bit          WAIT_VBLANK = 1'b1,
  parameter logic [3:0]  ADDR_RESET  = 4'd0,
  parameter logic [3:0]  ADDR_COL    = 4'd1,
  parameter logic [3:0]  ADDR_STATUS = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [15:0] col_top,
  input  logic [15:0] col_height,
  input  logic        col_wall_dir,
  input  logic [2:0]  col_tex_type,
  input  logic [5:0]  col_tex_col,
  input  logic [31:0] col_sf,
  output logic [3:0]  avm_address,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  output logic        avm_read,
  input  logic [15:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        frame_done,
  output logic [9:0]  col_count,
  output logic        err_overrun,
  output logic [2:0]  dbg_state
);

  // Record handshake: a record transfers on a rising clk edge where col_valid
  // and col_ready are both high; col_ready is high only in WAITC, so a record
  // offered at any other time simply waits.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VSYNC = 3'd1,
    RSTW  = 3'd2,
    WAITC = 3'd3,
    SEND  = 3'd4
  } state_t;

  localparam logic [9:0] LAST_COL = 10'(NCOLS - 1);

  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [9:0]  col_count_q, col_count_d;
  logic        err_overrun_q, err_overrun_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] top_q, top_d;
  logic [15:0] height_q, height_d;
  logic [31:0] sf_q, sf_d;
  logic        beat_done;
  logic [15:0] next_beat;
  logic        unused_readdata;

  // Only bit 0 (vblank) of the status word carries meaning.
  assign unused_readdata = ^avm_readdata[15:1];

  assign beat_done = (write_q | read_q) & ~avm_waitrequest;

  always_comb begin
    next_beat = sf_q[15:0];
    case (beat_q)
      3'd0:    next_beat = height_q;
      3'd1:    next_beat = top_q;
      3'd2:    next_beat = sf_q[31:16];
      default: next_beat = sf_q[15:0];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    col_count_d   = col_count_q;
    err_overrun_d = err_overrun_q;
    frame_done_d  = 1'b0;
    addr_d        = addr_q;
    write_d       = write_q;
    read_d        = read_q;
    wdata_d       = wdata_q;
    top_d         = top_q;
    height_d      = height_q;
    sf_d          = sf_q;

    if (frame_start) err_overrun_d = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          if (WAIT_VBLANK) begin
            state_d = VSYNC;
            read_d  = 1'b1;
            addr_d  = ADDR_STATUS;
          end else begin
            state_d = RSTW;
            write_d = 1'b1;
            addr_d  = ADDR_RESET;
            wdata_d = 16'd0;
          end
        end
      end
      VSYNC: begin
        // A read that returns vblank=0 is immediately followed by another read.
        if (beat_done && avm_readdata[0]) begin
          state_d = RSTW;
          read_d  = 1'b0;
          write_d = 1'b1;
          addr_d  = ADDR_RESET;
          wdata_d = 16'd0;
        end
      end
      RSTW: begin
        if (beat_done) begin
          write_d     = 1'b0;
          col_count_d = 10'd0;
          state_d     = WAITC;
        end
      end
      WAITC: begin
        if (col_valid) begin
          top_d    = col_top;
          height_d = col_height;
          sf_d     = col_sf;
          beat_d   = 3'd0;
          write_d  = 1'b1;
          addr_d   = ADDR_COL;
          wdata_d  = {6'b0, col_wall_dir, col_tex_type, col_tex_col};
          state_d  = SEND;
        end
      end
      SEND: begin
        if (beat_done) begin
          if (beat_q == 3'd4) begin
            write_d = 1'b0;
            if (col_count_q == LAST_COL) begin
              col_count_d  = 10'd0;
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              col_count_d = col_count_q + 10'd1;
              state_d     = WAITC;
            end
          end else begin
            beat_d  = beat_q + 3'd1;
            wdata_d = next_beat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= 3'd0;
      col_count_q   <= 10'd0;
      err_overrun_q <= 1'b0;
      frame_done_q  <= 1'b0;
      addr_q        <= 4'd0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      wdata_q       <= 16'd0;
      top_q         <= 16'd0;
      height_q      <= 16'd0;
      sf_q          <= 32'd0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      col_count_q   <= col_count_d;
      err_overrun_q <= err_overrun_d;
      frame_done_q  <= frame_done_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      read_q        <= read_d;
      wdata_q       <= wdata_d;
      top_q         <= top_d;
      height_q      <= height_d;
      sf_q          <= sf_d;
    end
  end

  assign col_ready     = (state_q == WAITC);
  assign busy          = (state_q != IDLE);
  assign avm_address   = addr_q;
  assign avm_write     = write_q;
  assign avm_read      = read_q;
  assign avm_writedata = wdata_q;
  assign frame_done    = frame_done_q;
  assign col_count     = col_count_q;
  assign err_overrun   = err_overrun_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_column_encoder.sv
// Bench for column_encoder: one instance without vblank polling for the frame
// tests, one with polling; bus beats are checked against a record-level model.
module tb_column_encoder;
  localparam int NCOLS = 640;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance without vblank polling
  logic        frame_start, col_valid, col_ready, col_wall_dir;
  logic [15:0] col_top, col_height;
  logic [2:0]  col_tex_type;
  logic [5:0]  col_tex_col;
  logic [31:0] col_sf;
  logic [3:0]  avm_address;
  logic        avm_write, avm_read, avm_waitrequest;
  logic [15:0] avm_writedata, avm_readdata;
  logic        busy, frame_done, err_overrun;
  logic [9:0]  col_count;
  logic [2:0]  dbg_state;

  // instance with vblank polling
  logic        frame_start_v, col_valid_v, col_ready_v;
  logic [3:0]  avm_address_v;
  logic        avm_write_v, avm_read_v;
  logic [15:0] avm_writedata_v, avm_readdata_v;
  logic        busy_v, frame_done_v, err_overrun_v;
  logic [9:0]  col_count_v;
  logic [2:0]  dbg_state_v;

  column_encoder #(.NCOLS(NCOLS), .WAIT_VBLANK(1'b0)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .col_valid(col_valid),
    .col_ready(col_ready), .col_top(col_top), .col_height(col_height),
    .col_wall_dir(col_wall_dir), .col_tex_type(col_tex_type), .col_tex_col(col_tex_col),
    .col_sf(col_sf), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .frame_done(frame_done),
    .col_count(col_count), .err_overrun(err_overrun), .dbg_state(dbg_state)
  );

  column_encoder #(.NCOLS(NCOLS), .WAIT_VBLANK(1'b1)) dut_v (
    .clk(clk), .reset(reset), .frame_start(frame_start_v), .col_valid(col_valid_v),
    .col_ready(col_ready_v), .col_top(16'd0), .col_height(16'd0),
    .col_wall_dir(1'b0), .col_tex_type(3'd0), .col_tex_col(6'd0),
    .col_sf(32'd0), .avm_address(avm_address_v), .avm_write(avm_write_v),
    .avm_writedata(avm_writedata_v), .avm_read(avm_read_v), .avm_readdata(avm_readdata_v),
    .avm_waitrequest(1'b0), .busy(busy_v), .frame_done(frame_done_v),
    .col_count(col_count_v), .err_overrun(err_overrun_v), .dbg_state(dbg_state_v)
  );

  int checks = 0;
  int errors = 0;
  bit to_flag = 1'b0;
  int start_cyc = 0;

  // record table and expected bus beats {address, data}
  logic [15:0] r_top[NCOLS];
  logic [15:0] r_height[NCOLS];
  logic [31:0] r_sf[NCOLS];
  int          r_dir[NCOLS];
  int          r_type[NCOLS];
  int          r_col[NCOLS];
  logic [19:0] exp_q[$];

  // bus monitor / slave for the non-polling instance
  logic [19:0] obs_q[$];
  bit          stall_en = 1'b0;
  bit          in_beat = 1'b0;
  bit          prev_pending = 1'b0;
  int          stall_left = 0;
  logic [3:0]  prev_addr;
  logic [15:0] prev_data;
  logic        prev_w, prev_r;
  int          stab_err = 0, overlap_err = 0, ready_hi = 0, done_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_beat = 1'b0;
      prev_pending = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      if ((avm_write || avm_read) && !in_beat) begin
        in_beat = 1'b1;
        stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
      end
      if (avm_write || avm_read) begin
        avm_waitrequest = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (prev_pending && (avm_address !== prev_addr || avm_writedata !== prev_data ||
                           avm_write !== prev_w || avm_read !== prev_r))
        stab_err++;
      if (avm_write && avm_read) overlap_err++;
      if ((avm_write || avm_read) && !avm_waitrequest) begin
        in_beat = 1'b0;
        if (avm_write) obs_q.push_back({avm_address, avm_writedata});
      end
      prev_pending = (avm_write || avm_read) && avm_waitrequest;
      prev_addr = avm_address;
      prev_data = avm_writedata;
      prev_w = avm_write;
      prev_r = avm_read;
      if (col_ready) ready_hi++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // status slave for the polling instance: vblank reads 0 for 5 polls, then 1
  logic [20:0] ev_v[$];
  int polls = 0;
  always @(negedge clk) begin
    if (reset) begin
      polls = 0;
      avm_readdata_v = 16'd0;
    end else begin
      if (avm_read_v) begin
        avm_readdata_v = {15'd0, polls >= 5};
        ev_v.push_back({1'b0, avm_address_v, 16'd0});
        polls++;
      end else begin
        avm_readdata_v = 16'd0;
      end
      if (avm_write_v) ev_v.push_back({1'b1, avm_address_v, avm_writedata_v});
    end
  end

  function automatic void fill(input bit rnd);
    for (int i = 0; i < NCOLS; i++) begin
      if (!rnd) begin
        r_top[i] = 16'(i); r_height[i] = 16'(2 * i); r_sf[i] = 32'h0100_0000 + 32'(i);
        r_dir[i] = i % 2; r_type[i] = i % 8; r_col[i] = i % 64;
      end else begin
        r_top[i] = 16'($urandom_range(0, 65535)); r_height[i] = 16'($urandom_range(0, 65535));
        r_sf[i] = $urandom; r_dir[i] = int'($urandom_range(0, 1));
        r_type[i] = int'($urandom_range(0, 7)); r_col[i] = int'($urandom_range(0, 63));
      end
    end
  endfunction

  function automatic void build_exp(input int n);
    exp_q.delete();
    exp_q.push_back({4'd0, 16'd0});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4'd1, 16'(r_dir[i] * 512 + r_type[i] * 64 + r_col[i])});
      exp_q.push_back({4'd1, r_height[i]});
      exp_q.push_back({4'd1, r_top[i]});
      exp_q.push_back({4'd1, 16'(r_sf[i] / 65536)});
      exp_q.push_back({4'd1, 16'(r_sf[i] % 65536)});
    end
  endfunction

  task automatic apply_reset;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1 start_cyc = cyc;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps) begin
        col_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      col_valid = 1'b1;
      col_top = r_top[i]; col_height = r_height[i]; col_sf = r_sf[i];
      col_wall_dir = 1'(r_dir[i]); col_tex_type = 3'(r_type[i]); col_tex_col = 6'(r_col[i]);
      t = 0;
      while (!col_ready && t < 200) begin
        @(negedge clk); t++;
      end
      if (t >= 200) to_flag = 1'b1;
      @(negedge clk);
    end
    col_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 20000) begin
      @(negedge clk); t++;
    end
    if (t >= 20000) to_flag = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({avm_address, avm_write, avm_writedata, avm_read, col_ready, busy, frame_done,
         col_count, err_overrun, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_outputs got addr=%h wr=%b data=%h rd=%b rdy=%b busy=%b cc=%0d exp all zero",
                         avm_address, avm_write, avm_writedata, avm_read, col_ready, busy, col_count);
    end
    checks++;
    if ({avm_address_v, avm_write_v, avm_writedata_v, avm_read_v, col_ready_v, busy_v,
         frame_done_v, col_count_v, err_overrun_v, dbg_state_v} !== '0) begin
      errors++; $display("FAIL reset_outputs_v got busy=%b rd=%b wr=%b exp all zero", busy_v, avm_read_v, avm_write_v);
    end
  endtask

  task automatic test_vblank;
    int t = 0;
    @(negedge clk); frame_start_v = 1'b1;
    @(negedge clk); frame_start_v = 1'b0;
    while (ev_v.size() < 7 && t < 100) begin
      @(negedge clk); t++;
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (ev_v.size() != 7) begin
      errors++; $display("FAIL vblank_events got %0d exp 7", ev_v.size());
    end
    for (int k = 0; k < 6 && k < ev_v.size(); k++) begin
      checks++;
      if (ev_v[k] !== {1'b0, 4'd0, 16'd0}) begin
        errors++; $display("FAIL vblank_read%0d got %h exp %h", k, ev_v[k], {1'b0, 4'd0, 16'd0});
      end
    end
    if (ev_v.size() > 6) begin
      checks++;
      if (ev_v[6] !== {1'b1, 4'd0, 16'd0}) begin
        errors++; $display("FAIL vblank_resetwrite got %h exp %h", ev_v[6], {1'b1, 4'd0, 16'd0});
      end
    end
    checks++;
    if (col_ready_v !== 1'b1 || busy_v !== 1'b1) begin
      errors++; $display("FAIL vblank_waitcol got rdy=%b busy=%b exp 1 1", col_ready_v, busy_v);
    end
  endtask

  task automatic test_frame;
    int base = obs_q.size();
    int d0 = done_cnt;
    fill(1'b0); build_exp(NCOLS);
    pulse_start; send_frame(NCOLS, 1'b0); wait_idle;
    checks++;
    if (to_flag) begin errors++; $display("FAIL t1_timeout got 1 exp 0"); to_flag = 1'b0; end
    checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL t1_beatcount got %0d exp %0d", obs_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[base + k] !== exp_q[k]) begin
        errors++; $display("FAIL t1_beat%0d got %h exp %h", k, obs_q[base + k], exp_q[k]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL t1_donecount got %0d exp 1", done_cnt - d0); end
    checks++;
    if (done_cyc - start_cyc != 1 + 6 * NCOLS) begin
      errors++; $display("FAIL t1_latency got %0d exp %0d", done_cyc - start_cyc, 1 + 6 * NCOLS);
    end
    checks++;
    if (col_count !== 10'd0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL t1_after got cc=%0d done=%b exp 0 0", col_count, frame_done);
    end
  endtask

  task automatic test_stall;
    int base = obs_q.size();
    int s0 = stab_err;
    int o0 = overlap_err;
    fill(1'b1); build_exp(NCOLS);
    stall_en = 1'b1;
    pulse_start; send_frame(NCOLS, 1'b1); wait_idle;
    stall_en = 1'b0;
    checks++;
    if (to_flag) begin errors++; $display("FAIL t2_timeout got 1 exp 0"); to_flag = 1'b0; end
    checks++;
    if (stab_err - s0 != 0) begin errors++; $display("FAIL t2_stable got %0d violations exp 0", stab_err - s0); end
    checks++;
    if (overlap_err - o0 != 0) begin errors++; $display("FAIL t2_rdwr got %0d overlaps exp 0", overlap_err - o0); end
    checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL t2_beatcount got %0d exp %0d", obs_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[base + k] !== exp_q[k]) begin
        errors++; $display("FAIL t2_beat%0d got %h exp %h", k, obs_q[base + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_overrun;
    int base = obs_q.size();
    int d0 = done_cnt;
    fill(1'b1); build_exp(NCOLS);
    pulse_start;
    fork
      send_frame(NCOLS, 1'b0);
      begin
        int t = 0;
        while (col_count != 10'd100 && t < 5000) begin
          @(negedge clk); t++;
        end
        if (t >= 5000) to_flag = 1'b1;
        frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
      end
    join
    wait_idle;
    checks++;
    if (to_flag) begin errors++; $display("FAIL t4_timeout got 1 exp 0"); to_flag = 1'b0; end
    checks++;
    if (err_overrun !== 1'b1) begin errors++; $display("FAIL t4_overrun_set got %b exp 1", err_overrun); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL t4_donecount got %0d exp 1", done_cnt - d0); end
    checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL t4_beatcount got %0d exp %0d", obs_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[base + k] !== exp_q[k]) begin
        errors++; $display("FAIL t4_beat%0d got %h exp %h", k, obs_q[base + k], exp_q[k]);
      end
    end
    pulse_start;
    #1;
    checks++;
    if (err_overrun !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t4_overrun_clear got err=%b busy=%b exp 0 1", err_overrun, busy);
    end
    apply_reset;
  endtask

  task automatic test_continuous;
    int base = obs_q.size();
    int r0 = ready_hi;
    fill(1'b1); build_exp(NCOLS);
    pulse_start; send_frame(NCOLS, 1'b0); wait_idle;
    checks++;
    if (to_flag) begin errors++; $display("FAIL t5_timeout got 1 exp 0"); to_flag = 1'b0; end
    checks++;
    if (ready_hi - r0 != NCOLS) begin errors++; $display("FAIL t5_readycycles got %0d exp %0d", ready_hi - r0, NCOLS); end
    checks++;
    if (done_cyc - start_cyc != 1 + 6 * NCOLS) begin
      errors++; $display("FAIL t5_latency got %0d exp %0d", done_cyc - start_cyc, 1 + 6 * NCOLS);
    end
    checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL t5_beatcount got %0d exp %0d", obs_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[base + k] !== exp_q[k]) begin
        errors++; $display("FAIL t5_beat%0d got %h exp %h", k, obs_q[base + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_async_reset;
    int base = obs_q.size();
    int t = 0;
    fill(1'b1);
    pulse_start; send_frame(8, 1'b0);
    // beats pushed: reset write, 7 full columns, then beats 0..2 of column 7
    while (obs_q.size() < base + 39 && t < 100) begin
      @(negedge clk); #1; t++;
    end
    checks++;
    if (avm_write !== 1'b1 || avm_writedata !== r_top[7] || col_count !== 10'd7) begin
      errors++; $display("FAIL t6_beat2 got wr=%b data=%h cc=%0d exp 1 %h 7", avm_write, avm_writedata, col_count, r_top[7]);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({avm_address, avm_write, avm_writedata, avm_read, col_ready, busy, frame_done,
         col_count, err_overrun, dbg_state} !== '0) begin
      errors++; $display("FAIL t6_async_zero got addr=%h wr=%b data=%h busy=%b cc=%0d exp all zero",
                         avm_address, avm_write, avm_writedata, busy, col_count);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    base = obs_q.size();
    build_exp(1);
    pulse_start; send_frame(1, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (to_flag) begin errors++; $display("FAIL t6_timeout got 1 exp 0"); to_flag = 1'b0; end
    checks++;
    if (obs_q.size() - base != 6) begin errors++; $display("FAIL t6_beatcount got %0d exp 6", obs_q.size() - base); end
    for (int k = 0; k < 6 && base + k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[base + k] !== exp_q[k]) begin
        errors++; $display("FAIL t6_beat%0d got %h exp %h", k, obs_q[base + k], exp_q[k]);
      end
    end
    checks++;
    if (col_count !== 10'd1) begin errors++; $display("FAIL t6_colcount got %0d exp 1", col_count); end
    apply_reset;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    frame_start = 1'b0; col_valid = 1'b0; col_top = '0; col_height = '0;
    col_wall_dir = 1'b0; col_tex_type = '0; col_tex_col = '0; col_sf = '0;
    avm_readdata = 16'd0; avm_waitrequest = 1'b0;
    frame_start_v = 1'b0; col_valid_v = 1'b0; avm_readdata_v = 16'd0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    test_vblank;
    test_frame;
    test_stall;
    test_overrun;
    test_continuous;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
